// File: rtl/ahb_slave_mem.sv
// AHB-Lite responder backed by a DEPTH x 32-bit register memory, with byte/half/word
// access, programmable wait states and the two-cycle ERROR response for illegal accesses.
module ahb_slave_mem #(
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic [1:0]  htrans,
    input  logic        hmastlock,
    input  logic        hready,
    input  logic [31:0] hwdata,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata
);

    localparam int          IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WAIT_LAST = 4'(WAIT_STATES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t          r_state;
    logic [3:0]      r_wait_cnt;
    logic [IW-1:0]   r_index;
    logic [1:0]      r_lane;
    logic [1:0]      r_size;
    logic            r_write;
    logic            r_hreadyout;
    logic            r_hresp;
    logic [31:0]     r_mem [DEPTH];

    logic            w_accept;
    logic            w_take;
    logic            w_legal;
    logic            w_commit;
    logic [3:0]      w_be;
    state_t          w_accept_state;
    logic            w_unused;

    // Sideband qualifiers carry no meaning for a simple memory; every beat is a single.
    assign w_unused = ^{hburst, hprot, hmastlock};

    assign w_accept = hsel & hready & htrans[1];

    // A new address phase can only land while this slave is presenting hreadyout=1.
    assign w_take = w_accept & ((r_state == S_IDLE) | (r_state == S_DATA) |
                                (r_state == S_ERR2));

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_legal = 1'b1;
        case (hsize)
            3'd0:    w_legal = 1'b1;
            3'd1:    w_legal = ~haddr[0];
            3'd2:    w_legal = (haddr[1:0] == 2'b00);
            default: w_legal = 1'b0;
        endcase
        if (haddr[31:2] >= 30'(DEPTH)) begin
            w_legal = 1'b0;
        end
    end

    always_comb begin
        w_accept_state = S_DATA;
        if (!w_legal) begin
            w_accept_state = S_ERR1;
        end else if (WAIT_STATES > 0) begin
            w_accept_state = S_WAIT;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // register in this block sees the pre-edge value of every other register.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= '0;
            r_index     <= '0;
            r_lane      <= '0;
            r_size      <= '0;
            r_write     <= 1'b0;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (r_wait_cnt == WAIT_LAST) begin
                        r_state     <= S_DATA;
                        r_hreadyout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end
                S_ERR1: begin
                    r_state     <= S_ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b1;
                end
                default: begin
                    // IDLE, DATA and ERR2 all complete a data phase and may start the next.
                    if (w_take) begin
                        r_index     <= haddr[IW+1:2];
                        r_lane      <= haddr[1:0];
                        r_size      <= hsize[1:0];
                        r_write     <= hwrite;
                        r_wait_cnt  <= '0;
                        r_state     <= w_accept_state;
                        r_hreadyout <= (w_accept_state == S_DATA);
                        r_hresp     <= ~w_legal;
                    end else begin
                        r_state     <= S_IDLE;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_be = 4'b0000;
        case (r_size)
            2'd0:    w_be[r_lane] = 1'b1;
            2'd1:    w_be = r_lane[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    // Only the DATA state commits, so ERROR beats and abandoned transfers never touch memory.
    assign w_commit = (r_state == S_DATA) & r_write;

    // NOTE: this memory is built from flops, so it can and does take the async reset;
    // an SRAM macro could not be cleared this way.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[r_index][8*b +: 8] <= hwdata[8*b +: 8];
                end
            end
        end
    end

    assign hreadyout = r_hreadyout;
    assign hresp     = r_hresp;

    // Read data comes straight from memory in the read's own data phase, so a write
    // committed on the edge that opened this phase is already visible.
    assign hrdata = ((r_state == S_DATA) && !r_write) ? r_mem[r_index] : 32'h0;

endmodule
